// File: rtl/rv32_wb_pkg.sv
// Shared types for the register-file writeback arbiter: pending-entry layout,
// slot-select encoding and the forwarding match helper.
package rv32_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic              killed;
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_EXU    = 2'd1,
        SEL_BUF    = 2'd2,
        SEL_BYPASS = 2'd3
    } wb_sel_e;

    // An entry forwards only while live and never for x0.
    function automatic logic fwd_match(input wb_entry_t e, input logic [REG_AW-1:0] addr);
        return e.valid && !e.killed && (e.waddr == addr) && (addr != {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/wb_pending_buf.sv
// Circular FIFO of deferred LSU load returns with kill-by-address and two
// newest-match forwarding lookups.
module wb_pending_buf
    import rv32_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                push,
    input  logic                push_killed,
    input  logic [REG_AW-1:0]   push_waddr,
    input  logic [XLEN-1:0]     push_wdata,
    input  logic                pop,
    input  logic                kill_en,
    input  logic [REG_AW-1:0]   kill_addr,
    input  logic [REG_AW-1:0]   raddr1,
    input  logic [REG_AW-1:0]   raddr2,
    output logic                hit1,
    output logic                hit2,
    output logic [XLEN-1:0]     data1,
    output logic [XLEN-1:0]     data2,
    output wb_entry_t           head,
    output logic                full,
    output logic                empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t       mem_r [DEPTH];
    logic [PW:0]     wr_ptr_r;
    logic [PW:0]     rd_ptr_r;
    logic [PW-1:0]   wr_idx_s;
    logic [PW-1:0]   rd_idx_s;

    assign wr_idx_s = wr_ptr_r[PW-1:0];
    assign rd_idx_s = rd_ptr_r[PW-1:0];
    assign full     = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_idx_s == rd_idx_s);
    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign head     = mem_r[rd_idx_s];

    // Storage and pointers: kill sweep first, then pop, then push into a distinct slot.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem_r[i].valid && (mem_r[i].waddr == kill_addr)) begin
                    mem_r[i].killed <= 1'b1;
                end
            end
            if (pop) begin
                mem_r[rd_idx_s].valid <= 1'b0;
                rd_ptr_r              <= rd_ptr_r + (PW+1)'(1);
            end
            if (push) begin
                mem_r[wr_idx_s].valid  <= 1'b1;
                mem_r[wr_idx_s].killed <= push_killed;
                mem_r[wr_idx_s].waddr  <= push_waddr;
                mem_r[wr_idx_s].wdata  <= push_wdata;
                wr_ptr_r               <= wr_ptr_r + (PW+1)'(1);
            end
        end
    end

    // Forwarding lookup: walk oldest to newest so the newest live match wins.
    always_comb begin
        logic [PW-1:0] idx_s;
        logic          m1_s;
        logic          m2_s;
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = {XLEN{1'b0}};
        data2 = {XLEN{1'b0}};
        idx_s = rd_idx_s;
        m1_s  = 1'b0;
        m2_s  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = rd_idx_s + PW'(k);
            m1_s  = fwd_match(mem_r[idx_s], raddr1);
            m2_s  = fwd_match(mem_r[idx_s], raddr2);
            hit1  = hit1 | m1_s;
            hit2  = hit2 | m2_s;
            data1 = m1_s ? mem_r[idx_s].wdata : data1;
            data2 = m2_s ? mem_r[idx_s].wdata : data2;
        end
    end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Register-file write-port arbiter: EXU always wins, LSU returns are bypassed
// or deferred into a pending buffer that is drained with starvation protection.
module rv32_wb_arbiter #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_n,
    input  logic                              exu_wen_i,
    input  logic [rv32_wb_pkg::REG_AW-1:0]    exu_waddr_i,
    input  logic [XLEN-1:0]                   exu_wdata_i,
    output logic                              exu_stall_o,
    input  logic                              lsu_valid_i,
    output logic                              lsu_ready_o,
    input  logic [rv32_wb_pkg::REG_AW-1:0]    lsu_waddr_i,
    input  logic [XLEN-1:0]                   lsu_wdata_i,
    input  logic [rv32_wb_pkg::REG_AW-1:0]    fwd_raddr1_i,
    input  logic [rv32_wb_pkg::REG_AW-1:0]    fwd_raddr2_i,
    output logic                              fwd_hit1_o,
    output logic                              fwd_hit2_o,
    output logic [XLEN-1:0]                   fwd_data1_o,
    output logic [XLEN-1:0]                   fwd_data2_o,
    output logic                              reg_wen_o,
    output logic [rv32_wb_pkg::REG_AW-1:0]    reg_waddr_o,
    output logic [XLEN-1:0]                   reg_wdata_o
);

    import rv32_wb_pkg::*;

    localparam int DW = $clog2(MAX_DEFER + 1);

    wb_entry_t          head_s;
    wb_sel_e            sel_s;
    logic               full_s;
    logic               empty_s;
    logic               lsu_acc_s;
    logic               lsu_keep_s;
    logic               push_s;
    logic               pop_s;
    logic               kill_en_s;
    logic               push_killed_s;
    logic               stall_r;
    logic [DW-1:0]      defer_r;
    logic [DW-1:0]      defer_nxt_s;
    logic               wen_nxt_s;
    logic [REG_AW-1:0]  waddr_nxt_s;
    logic [XLEN-1:0]    wdata_nxt_s;
    logic               reg_wen_r;
    logic [REG_AW-1:0]  reg_waddr_r;
    logic [XLEN-1:0]    reg_wdata_r;

    // Beats to x0 are accepted but never occupy the buffer or the write slot.
    assign lsu_ready_o   = !full_s;
    assign lsu_acc_s     = lsu_valid_i && !full_s;
    assign lsu_keep_s    = lsu_acc_s && (lsu_waddr_i != {REG_AW{1'b0}});
    assign pop_s         = (sel_s == SEL_BUF) && !empty_s;
    assign push_s        = lsu_keep_s && ((sel_s == SEL_EXU) || (sel_s == SEL_BUF));
    assign kill_en_s     = (sel_s == SEL_EXU) && (exu_waddr_i != {REG_AW{1'b0}});
    assign push_killed_s = kill_en_s && (lsu_waddr_i == exu_waddr_i);

    // Slot priority; a pending drain slot pre-empts EXU.
    always_comb begin
        sel_s = SEL_NONE;
        if (stall_r) begin
            sel_s = SEL_BUF;
        end else if (exu_wen_i) begin
            sel_s = SEL_EXU;
        end else if (!empty_s) begin
            sel_s = SEL_BUF;
        end else if (lsu_keep_s) begin
            sel_s = SEL_BYPASS;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Write-slot contents for the selected source.
    always_comb begin
        wen_nxt_s   = 1'b0;
        waddr_nxt_s = {REG_AW{1'b0}};
        wdata_nxt_s = {XLEN{1'b0}};
        case (sel_s)
            SEL_EXU: begin
                wen_nxt_s   = (exu_waddr_i != {REG_AW{1'b0}});
                waddr_nxt_s = exu_waddr_i;
                wdata_nxt_s = exu_wdata_i;
            end
            SEL_BUF: begin
                wen_nxt_s   = head_s.valid && !head_s.killed && (head_s.waddr != {REG_AW{1'b0}});
                waddr_nxt_s = head_s.waddr;
                wdata_nxt_s = head_s.wdata;
            end
            SEL_BYPASS: begin
                wen_nxt_s   = 1'b1;
                waddr_nxt_s = lsu_waddr_i;
                wdata_nxt_s = lsu_wdata_i;
            end
            default: begin
                wen_nxt_s   = 1'b0;
                waddr_nxt_s = {REG_AW{1'b0}};
                wdata_nxt_s = {XLEN{1'b0}};
            end
        endcase
    end

    // Defer counter: counts head losses to EXU, cleared by any pop or an empty buffer.
    always_comb begin
        defer_nxt_s = defer_r;
        if (empty_s || pop_s) begin
            defer_nxt_s = {DW{1'b0}};
        end else if (sel_s == SEL_EXU) begin
            defer_nxt_s = defer_r + DW'(1);
        end else begin
            defer_nxt_s = defer_r;
        end
    end

    // State and output registers; address/data are zeroed on idle slots.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            defer_r     <= {DW{1'b0}};
            stall_r     <= 1'b0;
            reg_wen_r   <= 1'b0;
            reg_waddr_r <= {REG_AW{1'b0}};
            reg_wdata_r <= {XLEN{1'b0}};
        end else begin
            defer_r     <= defer_nxt_s;
            stall_r     <= (defer_nxt_s == DW'(MAX_DEFER));
            reg_wen_r   <= wen_nxt_s;
            reg_waddr_r <= wen_nxt_s ? waddr_nxt_s : {REG_AW{1'b0}};
            reg_wdata_r <= wen_nxt_s ? wdata_nxt_s : {XLEN{1'b0}};
        end
    end

    assign exu_stall_o = stall_r;
    assign reg_wen_o   = reg_wen_r;
    assign reg_waddr_o = reg_waddr_r;
    assign reg_wdata_o = reg_wdata_r;

    wb_pending_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .push        (push_s),
        .push_killed (push_killed_s),
        .push_waddr  (lsu_waddr_i),
        .push_wdata  (lsu_wdata_i),
        .pop         (pop_s),
        .kill_en     (kill_en_s),
        .kill_addr   (exu_waddr_i),
        .raddr1      (fwd_raddr1_i),
        .raddr2      (fwd_raddr2_i),
        .hit1        (fwd_hit1_o),
        .hit2        (fwd_hit2_o),
        .data1       (fwd_data1_o),
        .data2       (fwd_data2_o),
        .head        (head_s),
        .full        (full_s),
        .empty       (empty_s)
    );

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed bench for rv32_wb_arbiter with hand-computed expectations.
module tb_rv32_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        exu_wen_i = 1'b0;
    logic [4:0]  exu_waddr_i = 5'd0;
    logic [31:0] exu_wdata_i = 32'd0;
    logic        exu_stall_o;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_waddr_i = 5'd0;
    logic [31:0] lsu_wdata_i = 32'd0;
    logic [4:0]  fwd_raddr1_i = 5'd0;
    logic [4:0]  fwd_raddr2_i = 5'd0;
    logic        fwd_hit1_o;
    logic        fwd_hit2_o;
    logic [31:0] fwd_data1_o;
    logic [31:0] fwd_data2_o;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    rv32_wb_arbiter #(.XLEN(32), .DEPTH(4), .MAX_DEFER(8)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .exu_wen_i    (exu_wen_i),
        .exu_waddr_i  (exu_waddr_i),
        .exu_wdata_i  (exu_wdata_i),
        .exu_stall_o  (exu_stall_o),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_waddr_i  (lsu_waddr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .fwd_raddr1_i (fwd_raddr1_i),
        .fwd_raddr2_i (fwd_raddr2_i),
        .fwd_hit1_o   (fwd_hit1_o),
        .fwd_hit2_o   (fwd_hit2_o),
        .fwd_data1_o  (fwd_data1_o),
        .fwd_data2_o  (fwd_data2_o),
        .reg_wen_o    (reg_wen_o),
        .reg_waddr_o  (reg_waddr_o),
        .reg_wdata_o  (reg_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic wen, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_wen"}, {31'd0, reg_wen_o}, {31'd0, wen});
        chk({tag, "_waddr"}, {27'd0, reg_waddr_o}, {27'd0, a});
        chk({tag, "_wdata"}, reg_wdata_o, d);
    endtask

    // The EXU side of the bench must never write during a drain slot.
    always @(negedge clk_i) begin
        if (rst_n && exu_stall_o) begin
            chk("stall_protocol", {31'd0, exu_wen_i}, 32'd0);
        end
    end

    initial begin
        // Reset state
        #2;
        chk_reg("reset", 1'b0, 5'd0, 32'd0);
        chk("reset_stall", {31'd0, exu_stall_o}, 32'd0);
        chk("reset_ready", {31'd0, lsu_ready_o}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Idle LSU beat bypasses the buffer
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd5; lsu_wdata_i = 32'hDEADBEEF;
        chk("bypass_ready", {31'd0, lsu_ready_o}, 32'd1);
        tick();
        lsu_valid_i = 1'b0; fwd_raddr1_i = 5'd5;
        #1;
        chk_reg("bypass", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("bypass_no_buf", {31'd0, fwd_hit1_o}, 32'd0);
        tick();
        chk_reg("bypass_idle", 1'b0, 5'd0, 32'd0);

        // EXU and LSU in the same cycle: EXU first, LSU next, forwarded meanwhile
        exu_wen_i = 1'b1; exu_waddr_i = 5'd3; exu_wdata_i = 32'h11;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h22;
        tick();
        exu_wen_i = 1'b0; lsu_valid_i = 1'b0; fwd_raddr1_i = 5'd7; fwd_raddr2_i = 5'd3;
        #1;
        chk_reg("both_exu", 1'b1, 5'd3, 32'h11);
        chk("both_fwd1_hit", {31'd0, fwd_hit1_o}, 32'd1);
        chk("both_fwd1_data", fwd_data1_o, 32'h22);
        chk("both_fwd2_hit", {31'd0, fwd_hit2_o}, 32'd0);
        chk("both_fwd2_data", fwd_data2_o, 32'd0);
        tick();
        chk_reg("both_lsu", 1'b1, 5'd7, 32'h22);
        chk("both_fwd_after_pop", {31'd0, fwd_hit1_o}, 32'd0);
        tick();
        chk_reg("both_idle", 1'b0, 5'd0, 32'd0);

        // Buffered x9 killed by a younger EXU write to x9
        exu_wen_i = 1'b1; exu_waddr_i = 5'd1; exu_wdata_i = 32'h1;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd9; lsu_wdata_i = 32'hAA;
        tick();
        lsu_valid_i = 1'b0; exu_waddr_i = 5'd9; exu_wdata_i = 32'hBB; fwd_raddr1_i = 5'd9;
        #1;
        chk_reg("kill_exu1", 1'b1, 5'd1, 32'h1);
        chk("kill_fwd_before_hit", {31'd0, fwd_hit1_o}, 32'd1);
        chk("kill_fwd_before_data", fwd_data1_o, 32'hAA);
        tick();
        exu_wen_i = 1'b0;
        #1;
        chk_reg("kill_exu9", 1'b1, 5'd9, 32'hBB);
        chk("kill_fwd_after_hit", {31'd0, fwd_hit1_o}, 32'd0);
        chk("kill_fwd_after_data", fwd_data1_o, 32'd0);
        tick();
        chk_reg("kill_pop", 1'b0, 5'd0, 32'd0);
        tick();
        chk_reg("kill_idle", 1'b0, 5'd0, 32'd0);

        // Same-cycle EXU and LSU to one register: the LSU beat is killed on entry
        exu_wen_i = 1'b1; exu_waddr_i = 5'd12; exu_wdata_i = 32'h1;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd12; lsu_wdata_i = 32'h2;
        tick();
        exu_wen_i = 1'b0; lsu_valid_i = 1'b0;
        chk_reg("samekill_exu", 1'b1, 5'd12, 32'h1);
        tick();
        chk_reg("samekill_pop", 1'b0, 5'd0, 32'd0);

        // x0 writes from both sources are dropped
        exu_wen_i = 1'b1; exu_waddr_i = 5'd0; exu_wdata_i = 32'h55;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd0; lsu_wdata_i = 32'h66;
        tick();
        exu_wen_i = 1'b0; lsu_valid_i = 1'b0; fwd_raddr1_i = 5'd0;
        #1;
        chk_reg("x0", 1'b0, 5'd0, 32'd0);
        chk("x0_fwd", {31'd0, fwd_hit1_o}, 32'd0);
        chk("x0_ready", {31'd0, lsu_ready_o}, 32'd1);
        tick();
        chk_reg("x0_after", 1'b0, 5'd0, 32'd0);

        // Fill under continuous EXU writes, then the starvation drain slot
        exu_waddr_i = 5'd20;
        for (int k = 0; k < 9; k++) begin
            exu_wen_i   = 1'b1;
            exu_wdata_i = 32'(k);
            lsu_valid_i = (k < 4);
            lsu_waddr_i = 5'(10 + k);
            lsu_wdata_i = 32'h100 + 32'(k);
            if (k < 4) chk("fill_ready_pre", {31'd0, lsu_ready_o}, 32'd1);
            tick();
            chk_reg("fill_exu", 1'b1, 5'd20, 32'(k));
            chk("fill_ready_post", {31'd0, lsu_ready_o}, (k >= 3) ? 32'd0 : 32'd1);
            chk("fill_stall", {31'd0, exu_stall_o}, (k == 8) ? 32'd1 : 32'd0);
        end
        exu_wen_i = 1'b0; lsu_valid_i = 1'b0;
        tick();
        chk_reg("drain_head", 1'b1, 5'd10, 32'h100);
        chk("drain_stall_once", {31'd0, exu_stall_o}, 32'd0);
        chk("drain_ready", {31'd0, lsu_ready_o}, 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk_reg("drain_rest", 1'b1, 5'(10 + k), 32'h100 + 32'(k));
        end
        tick();
        chk_reg("drain_done", 1'b0, 5'd0, 32'd0);

        // Reset with three entries pending
        exu_wen_i = 1'b1; exu_waddr_i = 5'd21; exu_wdata_i = 32'h77;
        for (int k = 0; k < 3; k++) begin
            lsu_valid_i = 1'b1;
            lsu_waddr_i = 5'(14 + k);
            lsu_wdata_i = 32'h200 + 32'(k);
            tick();
        end
        exu_wen_i = 1'b0; lsu_valid_i = 1'b0; fwd_raddr1_i = 5'd15;
        #1;
        chk_reg("prerst_exu", 1'b1, 5'd21, 32'h77);
        chk("prerst_fwd_hit", {31'd0, fwd_hit1_o}, 32'd1);
        chk("prerst_fwd_data", fwd_data1_o, 32'h201);
        rst_n = 1'b0;
        #1;
        chk_reg("midrst", 1'b0, 5'd0, 32'd0);
        chk("midrst_stall", {31'd0, exu_stall_o}, 32'd0);
        chk("midrst_fwd", {31'd0, fwd_hit1_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_reg("postrst1", 1'b0, 5'd0, 32'd0);
        chk("postrst_ready", {31'd0, lsu_ready_o}, 32'd1);
        tick();
        chk_reg("postrst2", 1'b0, 5'd0, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rv32_wb_arbiter.md
Name: rv32_wb_arbiter

Overview:
- Shares the single general-register write port between the EXU writeback path and the LSU load-return path.
- EXU writes are never back-pressured and always win.
- LSU returns that lose arbitration are held in a small pending buffer. The buffer also provides forwarding lookup and starvation protection.
- Sits between EXU/LSU and the register file in the priRV32 top level; drives the file's we/waddr/wdata inputs.

Parameters:
- XLEN, 32, data width.
- DEPTH, 4, LSU pending-buffer entries; power of two, minimum 2.
- MAX_DEFER, 8, consecutive cycles the buffer head may lose to EXU before a forced drain slot.

Ports:
- clk_i  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- exu_wen_i  in  1  EXU writeback valid.
- exu_waddr_i  in  5  EXU destination register.
- exu_wdata_i  in  XLEN  EXU write data.
- exu_stall_o  out  1  forced-drain request; EXU holds exu_wen_i=0 while high.
- lsu_valid_i  in  1  LSU load-return valid.
- lsu_ready_o  out  1  arbiter can accept an LSU beat this cycle.
- lsu_waddr_i  in  5  LSU destination register.
- lsu_wdata_i  in  XLEN  LSU load data.
- fwd_raddr1_i  in  5  forwarding lookup address, port 1.
- fwd_raddr2_i  in  5  forwarding lookup address, port 2.
- fwd_hit1_o  out  1  port 1 lookup hit.
- fwd_hit2_o  out  1  port 2 lookup hit.
- fwd_data1_o  out  XLEN  port 1 forwarded data.
- fwd_data2_o  out  XLEN  port 2 forwarded data.
- reg_wen_o  out  1  register-file write enable, registered.
- reg_waddr_o  out  5  register-file write address, registered.
- reg_wdata_o  out  XLEN  register-file write data, registered.

Behaviour:
- Reset (async, rst_n low): buffer emptied; defer counter cleared; reg_wen_o, reg_waddr_o, reg_wdata_o all 0; exu_stall_o 0.
- LSU handshake: lsu_ready_o = buffer not full, derived combinationally from state. A beat is accepted when lsu_valid_i && lsu_ready_o. No push-while-full, even if a pop happens in the same cycle.
- Write-slot priority, evaluated each cycle (result registered, 1-cycle latency to reg_*_o):
  1. EXU write present: EXU is written. An accepted LSU beat is pushed to the buffer.
  2. Otherwise, buffer non-empty: buffer head is popped and written. An accepted LSU beat is pushed behind it.
  3. Otherwise: an accepted LSU beat bypasses the buffer and is written directly.
  4. Otherwise: reg_wen_o = 0.
- Program-order rule: EXU writes are younger than every pending LSU entry.
  - An EXU write to register A kills every valid buffer entry with waddr A.
  - An LSU beat accepted in the same cycle to the same A is also killed.
  - A killed entry keeps its FIFO slot. On pop it is discarded with reg_wen_o = 0 and consumes that write slot.
- x0: writes to x0 from either source are dropped. An LSU beat to x0 is accepted and discarded, never buffered. The output write enable is never asserted for address 0.
- Starvation:
  - defer_cnt increments when the buffer is non-empty and EXU wins the slot.
  - It clears on any buffer pop or when the buffer is empty.
  - When defer_cnt == MAX_DEFER, exu_stall_o = 1 for exactly one cycle and the head is popped that cycle; defer_cnt then clears.
  - An EXU write arriving while exu_stall_o is high is a protocol violation; the bench asserts it never happens.
- Forwarding: combinational, from buffer contents only.
  - Hit = newest valid, non-killed entry whose waddr equals the lookup address.
  - Lookup address 0 never hits.
  - Entries accepted this cycle are not visible until the next cycle.
  - On a miss, fwd_data = 0.
- Wrap-around: read/write pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the low bits are equal.
- Reset mid-operation: pending entries are lost. The LSU must reissue; this is not the arbiter's responsibility.

Decomposition:
- Package rv32_wb_pkg:
  - XLEN, REG_AW=5.
  - wb_entry_t {valid, killed, waddr, wdata}.
  - Priority select encoding {SEL_NONE, SEL_EXU, SEL_BUF, SEL_BYPASS}.
- Sub-module wb_pending_buf:
  - Circular FIFO with per-entry kill-by-address compare.
  - Two newest-match forwarding lookups.
  - Exposes full/empty.
- rv32_wb_arbiter holds the select logic, defer counter and output register.

Test Plan:
- Idle, then LSU beat x5=0xDEADBEEF → next cycle reg_wen_o=1, waddr=5, wdata=0xDEADBEEF; buffer stays empty.
- EXU x3=0x11 and LSU x7=0x22 in the same cycle → cycle+1 writes x3=0x11; cycle+2 writes x7=0x22; fwd_raddr1_i=7 hits 0x22 during the intervening cycle.
- EXU writes continuously while LSU fills 4 entries → lsu_ready_o drops after the 4th accept; after 8 deferred cycles exu_stall_o pulses once and the head drains.
- LSU x9=0xAA buffered, then EXU x9=0xBB → reg writes x9=0xBB only; the killed entry pops with reg_wen_o=0; fwd on x9 misses after the kill.
- LSU beat and EXU write both to x0 → reg_wen_o stays 0; buffer empty.
- rst_n asserted with 3 buffered entries → all outputs 0 immediately; lsu_ready_o=1 after release; no stale writes.
